mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / load-store memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_LSU = 2'd2,
        DRAIN_IF = 2'd3
    } mem_arb_state_e;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    localparam logic [3:0] IF_BE = 4'hF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and load/store,
// favouring LSU but bounding how long a waiting fetch can be starved.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_sync,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [3:0]  lsu_be,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_gnt,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,

    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,

    input  logic        flush,
    output logic        stall_req
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    mem_arb_state_e   state_reg;
    logic [CNT_W-1:0] starve_cnt_reg;
    logic             bus_req_reg;
    logic             bus_we_reg;
    logic [3:0]       bus_be_reg;
    logic [31:0]      bus_addr_reg;
    logic [31:0]      bus_wdata_reg;

    logic             pick_lsu;
    logic             pick_if;
    logic             if_starved;

    // A starved fetch only wins if it is actually eligible (not being flushed).
    assign if_starved = if_req && !flush && (starve_cnt_reg == CNT_MAX);

    always_comb begin
        pick_lsu = 1'b0;
        pick_if  = 1'b0;
        if (state_reg == IDLE && !rst_sync) begin
            if (lsu_req && !if_starved) begin
                pick_lsu = 1'b1;
            end else if (if_req && !flush) begin
                pick_if = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
            bus_req_reg    <= 1'b0;
            bus_we_reg     <= 1'b0;
            bus_be_reg     <= 4'h0;
            bus_addr_reg   <= 32'h0;
            bus_wdata_reg  <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_lsu) begin
                        state_reg     <= BUSY_LSU;
                        bus_req_reg   <= 1'b1;
                        bus_we_reg    <= lsu_we;
                        bus_be_reg    <= lsu_be;
                        bus_addr_reg  <= lsu_addr;
                        bus_wdata_reg <= lsu_wdata;
                        if (if_req && starve_cnt_reg != CNT_MAX) begin
                            starve_cnt_reg <= starve_cnt_reg + 1'b1;
                        end
                    end else if (pick_if) begin
                        state_reg      <= BUSY_IF;
                        bus_req_reg    <= 1'b1;
                        bus_we_reg     <= 1'b0;
                        bus_be_reg     <= IF_BE;
                        bus_addr_reg   <= if_addr;
                        bus_wdata_reg  <= 32'h0;
                        starve_cnt_reg <= '0;
                    end
                end
                BUSY_IF: begin
                    if (bus_ready) begin
                        state_reg   <= IDLE;
                        bus_req_reg <= 1'b0;
                    end else if (flush) begin
                        // The bus cannot be aborted; finish it silently.
                        state_reg <= DRAIN_IF;
                    end
                end
                BUSY_LSU, DRAIN_IF: begin
                    if (bus_ready) begin
                        state_reg   <= IDLE;
                        bus_req_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    bus_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt     = pick_if;
    assign lsu_gnt    = pick_lsu;
    assign if_rvalid  = (state_reg == BUSY_IF) && bus_ready && !flush;
    assign lsu_rvalid = (state_reg == BUSY_LSU) && bus_ready;
    assign if_rdata   = bus_rdata;
    assign lsu_rdata  = bus_rdata;

    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_be    = bus_be_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;

    assign stall_req = (lsu_req && !lsu_gnt) || ((state_reg == BUSY_LSU) && !bus_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst_sync;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        lsu_req;
    logic        lsu_we;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_gnt;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        flush;
    logic        stall_req;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst_sync   (rst_sync),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .lsu_req    (lsu_req),
        .lsu_we     (lsu_we),
        .lsu_be     (lsu_be),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_gnt    (lsu_gnt),
        .lsu_rvalid (lsu_rvalid),
        .lsu_rdata  (lsu_rdata),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_be     (bus_be),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ready  (bus_ready),
        .bus_rdata  (bus_rdata),
        .flush      (flush),
        .stall_req  (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model of the outstanding bus transaction (at most one exists).
    logic        m_busy     = 1'b0;
    logic        m_lsu      = 1'b0;
    logic        m_cancel   = 1'b0;
    logic        m_we       = 1'b0;
    logic [3:0]  m_be       = 4'h0;
    logic [31:0] m_addr     = 32'h0;
    logic [31:0] m_wdata    = 32'h0;
    int          m_streak   = 0;
    logic        last_if_gnt  = 1'b0;
    logic        last_lsu_gnt = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic idle_inputs();
        rst_sync  = 1'b0;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        lsu_req   = 1'b0;
        lsu_we    = 1'b0;
        lsu_be    = 4'h0;
        lsu_addr  = 32'h0;
        lsu_wdata = 32'h0;
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        flush     = 1'b0;
    endtask

    // Inputs are already driven for this cycle; check all outputs, advance the model,
    // and move on to the next falling edge.
    task automatic step();
        logic g_if, g_lsu, rv_if, rv_lsu, done, stall;
        #1;
        g_if = 1'b0; g_lsu = 1'b0; rv_if = 1'b0; rv_lsu = 1'b0; done = 1'b0;
        if (rst_sync) begin
            m_busy = 1'b0; m_lsu = 1'b0; m_cancel = 1'b0;
            m_we = 1'b0; m_be = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
            m_streak = 0;
            stall = lsu_req;
        end else begin
            if (!m_busy) begin
                if (lsu_req && !(if_req && !flush && m_streak >= LIMIT)) g_lsu = 1'b1;
                else if (if_req && !flush) g_if = 1'b1;
            end else if (bus_ready) begin
                done = 1'b1;
                if (m_lsu) rv_lsu = 1'b1;
                else       rv_if  = !m_cancel && !flush;
            end
            stall = (lsu_req && !g_lsu) || (m_busy && m_lsu && !bus_ready);
        end

        check_val("if_gnt",     if_gnt,     g_if);
        check_val("lsu_gnt",    lsu_gnt,    g_lsu);
        check_val("if_rvalid",  if_rvalid,  rv_if);
        check_val("lsu_rvalid", lsu_rvalid, rv_lsu);
        check_val("stall_req",  stall_req,  stall);
        check_val("bus_req",    bus_req,    m_busy);
        check_val("bus_we",     bus_we,     m_we);
        check_val("bus_be",     bus_be,     m_be);
        check_val("bus_addr",   bus_addr,   m_addr);
        check_val("bus_wdata",  bus_wdata,  m_wdata);
        if (rv_if)  check_val("if_rdata",  if_rdata,  bus_rdata);
        if (rv_lsu) check_val("lsu_rdata", lsu_rdata, bus_rdata);

        if (g_lsu) $display("cyc=%0d grant LSU we=%0d be=%h addr=%h", cyc, lsu_we, lsu_be, lsu_addr);
        if (g_if)  $display("cyc=%0d grant IF addr=%h", cyc, if_addr);

        if (!rst_sync) begin
            if (g_lsu) begin
                m_busy = 1'b1; m_lsu = 1'b1; m_cancel = 1'b0;
                m_we = lsu_we; m_be = lsu_be; m_addr = lsu_addr; m_wdata = lsu_wdata;
                if (if_req) m_streak = (m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1;
            end else if (g_if) begin
                m_busy = 1'b1; m_lsu = 1'b0; m_cancel = 1'b0;
                m_we = 1'b0; m_be = 4'hF; m_addr = if_addr; m_wdata = 32'h0;
                m_streak = 0;
            end else if (done) begin
                m_busy = 1'b0;
            end else if (m_busy && !m_lsu && flush) begin
                m_cancel = 1'b1;
            end
        end
        last_if_gnt  = g_if;
        last_lsu_gnt = g_lsu;
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive_random();
        if (!if_req || last_if_gnt) begin
            if_req  = ($urandom_range(0, 9) < 6);
            if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!lsu_req || last_lsu_gnt) begin
            lsu_req   = ($urandom_range(0, 9) < 5);
            lsu_we    = 1'($urandom_range(0, 1));
            lsu_be    = 4'($urandom_range(0, 15));
            lsu_addr  = $urandom;
            lsu_wdata = $urandom;
        end
        flush     = ($urandom_range(0, 9) == 0);
        bus_ready = ($urandom_range(0, 2) != 0);
        bus_rdata = $urandom;
        rst_sync  = ($urandom_range(0, 99) == 0);
    endtask

    initial begin
        int k;
        idle_inputs();
        rst_sync = 1'b1;
        @(negedge clk);

        // Reset state, with a pending LSU request visible through stall_req.
        lsu_req = 1'b1;
        #1;
        check_val("rst_stall", stall_req, 1'b1);
        check_val("rst_lsu_gnt", lsu_gnt, 1'b0);
        step();
        idle_inputs();
        step();

        // IF-only fetch, one bus cycle.
        if_req = 1'b1; if_addr = 32'h100;
        #1; check_val("s35_if_gnt", if_gnt, 1'b1);
        step();
        if_req = 1'b0; bus_ready = 1'b1; bus_rdata = 32'hCAFE_0001;
        #1; check_val("s35_bus_req", bus_req, 1'b1);
        check_val("s35_if_rvalid", if_rvalid, 1'b1);
        check_val("s35_if_rdata", if_rdata, 32'hCAFE_0001);
        step();
        bus_ready = 1'b0;
        #1; check_val("s35_idle", bus_req, 1'b0);
        step();

        // Store with three waiting bus cycles.
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'b0011; lsu_addr = 32'h2000; lsu_wdata = 32'h1234_5678;
        step();
        lsu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; check_val("s36_stall_hi", stall_req, 1'b1);
            check_val("s36_bus_be", bus_be, 4'b0011);
            check_val("s36_bus_we", bus_we, 1'b1);
            step();
        end
        bus_ready = 1'b1;
        #1; check_val("s36_rvalid", lsu_rvalid, 1'b1);
        check_val("s36_stall_lo", stall_req, 1'b0);
        step();
        idle_inputs();
        step();

        // Continuous contention: four LSU grants then one IF grant, repeating.
        k = 0;
        if_req = 1'b1; if_addr = 32'h400; lsu_req = 1'b1; lsu_addr = 32'h3000; bus_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (if_gnt || lsu_gnt) begin
                check_val("s37_order_if", if_gnt, (k % 5) == 4);
                k++;
            end
            step();
        end
        check_val("s37_grants", k, 10);
        idle_inputs(); bus_ready = 1'b1;
        step(); step();
        idle_inputs();

        // Flush in the second BUSY_IF cycle, bus completes in the fourth.
        if_req = 1'b1; if_addr = 32'h500;
        step();
        if_req = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1; check_val("s38_drain_req", bus_req, 1'b1);
        step();
        bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        #1; check_val("s38_no_rvalid", if_rvalid, 1'b0);
        check_val("s38_held", bus_req, 1'b1);
        step();
        bus_ready = 1'b0;
        #1; check_val("s38_idle", bus_req, 1'b0);
        step();

        // Flush blocks an IF-only request; grant follows once flush drops.
        if_req = 1'b1; if_addr = 32'h600; flush = 1'b1;
        #1; check_val("s39_blocked", if_gnt, 1'b0);
        step();
        flush = 1'b0;
        #1; check_val("s39_granted", if_gnt, 1'b1);
        step();
        if_req = 1'b0; bus_ready = 1'b1;
        step();
        idle_inputs();

        // Reset during BUSY_LSU abandons the access.
        lsu_req = 1'b1; lsu_addr = 32'h7000;
        step();
        lsu_req = 1'b0;
        step();
        rst_sync = 1'b1;
        #1; check_val("s40_bus_req", bus_req, 1'b0);
        step();
        rst_sync = 1'b0; bus_ready = 1'b1;
        #1; check_val("s40_no_rvalid", lsu_rvalid, 1'b0);
        step();
        idle_inputs();
        step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
